mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 150 +++++++++++++++
 tb/tb_mem_access.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Multi-cycle load/store unit between the MEM stage and a word-wide data RAM.
// Byte/half stores use read-modify-write. Optional macro: MISALIGN_EXC_EN.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        busy,
    output logic        exc,
    output logic        memCe,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    input  logic [31:0] memRdata
);
    localparam logic [2:0] OpLw  = 3'b000;
    localparam logic [2:0] OpLb  = 3'b001;
    localparam logic [2:0] OpLbu = 3'b010;
    localparam logic [2:0] OpLh  = 3'b011;
    localparam logic [2:0] OpLhu = 3'b100;
    localparam logic [2:0] OpSw  = 3'b101;
    localparam logic [2:0] OpSb  = 3'b110;
    localparam logic [2:0] OpSh  = 3'b111;

    typedef enum logic [2:0] {StIdle, StLd, StRd, StWr, StResp} state_e;

    state_e      state_q, state_d;
    logic [31:0] rdata_q;
    logic [31:0] merge_q;
    logic [1:0]  lane;
    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] ld_fmt;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic        is_load;
    logic        misalign;
    logic        accept;

    assign is_load = (op <= OpLhu);
    assign accept  = (state_q == StIdle) && req;

    // Low address bits a given op ignores are forced to zero.
    always_comb begin
        lane = addr[1:0];
        unique case (op)
            OpLw, OpSw:        lane = 2'b00;
            OpLh, OpLhu, OpSh: lane = {addr[1], 1'b0};
            default:           lane = addr[1:0];
        endcase
    end

`ifdef MISALIGN_EXC_EN
    logic exc_q;
    always_comb begin
        unique case (op)
            OpLw, OpSw:        misalign = (addr[1:0] != 2'b00);
            OpLh, OpLhu, OpSh: misalign = addr[0];
            default:           misalign = 1'b0;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         exc_q <= 1'b0;
        else if (accept) exc_q <= misalign;
    end
    assign exc = exc_q;
`else
    assign misalign = 1'b0;
    assign exc      = 1'b0;
`endif

    assign shamt   = {lane, 3'b000};
    assign shifted = memRdata >> shamt;

    always_comb begin
        ld_fmt = memRdata;
        unique case (op)
            OpLb:    ld_fmt = {{24{shifted[7]}}, shifted[7:0]};
            OpLbu:   ld_fmt = {24'h0, shifted[7:0]};
            OpLh:    ld_fmt = {{16{shifted[15]}}, shifted[15:0]};
            OpLhu:   ld_fmt = {16'h0, shifted[15:0]};
            default: ld_fmt = memRdata;
        endcase
    end

    // Store lane merge: replace the selected byte/half of the fetched word.
    always_comb begin
        lane_mask = 32'h0000_00ff << shamt;
        lane_data = {24'h0, wdata[7:0]} << shamt;
        if (op == OpSh) begin
            lane_mask = 32'h0000_ffff << shamt;
            lane_data = {16'h0, wdata[15:0]} << shamt;
        end
    end

    assign memWdata = (op == OpSw) ? wdata : ((merge_q & ~lane_mask) | lane_data);
    assign memAddr  = {addr[31:2], 2'b00};

    always_comb begin
        state_d = state_q;
        memCe   = 1'b0;
        memWe   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (misalign)               state_d = StResp;
                    else if (is_load)           state_d = StLd;
                    else if (op == OpSw)        state_d = StWr;
                    else                        state_d = StRd;
                end
            end
            StLd: begin
                memCe   = 1'b1;
                state_d = StResp;
            end
            StRd: begin
                memCe   = 1'b1;
                state_d = StWr;
            end
            StWr: begin
                memCe   = 1'b1;
                memWe   = 1'b1;
                state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            rdata_q <= 32'h0;
            merge_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept)                rdata_q <= 32'h0;
            else if (state_q == StLd)  rdata_q <= ld_fmt;
            if (state_q == StRd)       merge_q <= memRdata;
        end
    end

    assign rdata = rdata_q;
    assign done  = (state_q == StResp);
    assign busy  = (state_q != StIdle);
endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access with a behavioural 1K-word RAM.
module tb_mem_access;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        done, busy, exc, memCe, memWe;
    logic [31:0] memAddr, memWdata, memRdata;

    logic [31:0] ram [0:1023];
    logic        pk_en = 1'b0;
    logic [9:0]  pk_idx = 10'h0;
    logic [31:0] pk_data = 32'h0;

    int n_checks = 0;
    int n_errors = 0;

    mem_access dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .rdata(rdata), .done(done), .busy(busy), .exc(exc),
        .memCe(memCe), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata)
    );

    always #5 clk = ~clk;

    assign memRdata = memCe ? ram[memAddr[11:2]] : 32'h0;

    always @(posedge clk) begin
        if (pk_en) ram[pk_idx] <= pk_data;
        else if (memCe && memWe) ram[memAddr[11:2]] <= memWdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pk_en = 1'b1; pk_idx = a[11:2]; pk_data = d;
        @(posedge clk); #1;
        pk_en = 1'b0;
    endtask

    // Issue one access; lat counts cycles after the accepting cycle until done.
    task automatic access(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                          output logic [31:0] rd, output logic ex, output int lat,
                          output logic [31:0] wword, output logic ce_seen,
                          output logic [31:0] maddr);
        @(negedge clk);
        op = o; addr = a; wdata = w; req = 1'b1;
        ce_seen = 1'b0; wword = 32'h0; maddr = 32'h0;
        @(posedge clk); #1;
        lat = 1;
        while (!done && lat < 20) begin
            if (memCe) begin ce_seen = 1'b1; maddr = memAddr; end
            if (memWe) wword = memWdata;
            @(posedge clk); #1;
            lat++;
        end
        rd = rdata; ex = exc;
        req = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [31:0] rd, ww, ma;
    logic        ex, ce;
    int          lat;
    logic        done_seen;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", rdata, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_ce", {31'h0, memCe}, 32'h0);
        check("rst_we", {31'h0, memWe}, 32'h0);
        check("rst_exc", {31'h0, exc}, 32'h0);
        @(negedge clk) rst = 1'b0;

        poke(32'h80, 32'h8899aabb);
        poke(32'h40, 32'h11223344);
        poke(32'h04, 32'h01234567);
        poke(32'h20, 32'hcafef00d);

        access(3'b001, 32'h83, 32'h0, rd, ex, lat, ww, ce, ma);
        check("lb83_rdata", rd, 32'hffffff88);
        check("lb83_lat", lat, 2);
        check("lb83_maddr", ma, 32'h80);
        access(3'b010, 32'h83, 32'h0, rd, ex, lat, ww, ce, ma);
        check("lbu83_rdata", rd, 32'h00000088);
        access(3'b001, 32'h80, 32'h0, rd, ex, lat, ww, ce, ma);
        check("lb80_rdata", rd, 32'hffffffbb);
        access(3'b010, 32'h81, 32'h0, rd, ex, lat, ww, ce, ma);
        check("lbu81_rdata", rd, 32'h000000aa);

        access(3'b111, 32'h42, 32'h0000beef, rd, ex, lat, ww, ce, ma);
        check("sh42_wword", ww, 32'hbeef3344);
        check("sh42_lat", lat, 3);
        check("sh42_rdata", rd, 32'h0);
        access(3'b000, 32'h40, 32'h0, rd, ex, lat, ww, ce, ma);
        check("lw40_rdata", rd, 32'hbeef3344);
        check("lw40_lat", lat, 2);

        access(3'b101, 32'h10, 32'hdeadbeef, rd, ex, lat, ww, ce, ma);
        check("sw10_lat", lat, 2);
        check("sw10_rdata", rd, 32'h0);
        check("sw10_ram", ram[4], 32'hdeadbeef);
        access(3'b011, 32'h12, 32'h0, rd, ex, lat, ww, ce, ma);
        check("lh12_rdata", rd, 32'hffffdead);
        access(3'b100, 32'h10, 32'h0, rd, ex, lat, ww, ce, ma);
        check("lhu10_rdata", rd, 32'h0000beef);
        access(3'b110, 32'h11, 32'h0000005a, rd, ex, lat, ww, ce, ma);
        check("sb11_lat", lat, 3);
        access(3'b000, 32'h10, 32'h0, rd, ex, lat, ww, ce, ma);
        check("sb11_readback", rd, 32'hdead5aef);

        access(3'b000, 32'h06, 32'h0, rd, ex, lat, ww, ce, ma);
`ifdef MISALIGN_EXC_EN
        check("lw06_lat", lat, 1);
        check("lw06_exc", {31'h0, ex}, 32'h1);
        check("lw06_rdata", rd, 32'h0);
        check("lw06_ce", {31'h0, ce}, 32'h0);
`else
        check("lw06_lat", lat, 2);
        check("lw06_exc", {31'h0, ex}, 32'h0);
        check("lw06_rdata", rd, 32'h01234567);
`endif

        // Reset while the SB write is on the RAM port.
        @(negedge clk);
        op = 3'b110; addr = 32'h21; wdata = 32'ha5; req = 1'b1;
        @(posedge clk); #1;
        check("sbrst_rd_we", {31'h0, memWe}, 32'h0);
        @(posedge clk); #1;
        check("sbrst_wr_we", {31'h0, memWe}, 32'h1);
        rst = 1'b1; req = 1'b0;
        #1;
        check("sbrst_done", {31'h0, done}, 32'h0);
        check("sbrst_busy", {31'h0, busy}, 32'h0);
        check("sbrst_ce", {31'h0, memCe}, 32'h0);
        check("sbrst_we", {31'h0, memWe}, 32'h0);
        check("sbrst_rdata", rdata, 32'h0);
        check("sbrst_exc", {31'h0, exc}, 32'h0);
        @(negedge clk) rst = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done) done_seen = 1'b1;
        end
        check("sbrst_no_done", {31'h0, done_seen}, 32'h0);
        check("sbrst_ram", ram[8], 32'hcafef00d);

        // Back-to-back LW with req held high.
        @(negedge clk);
        op = 3'b000; addr = 32'h40; req = 1'b1;
        @(posedge clk); #1;
        check("b2b_t1_busy", {31'h0, busy}, 32'h1);
        check("b2b_t1_done", {31'h0, done}, 32'h0);
        @(posedge clk); #1;
        check("b2b_t2_done", {31'h0, done}, 32'h1);
        check("b2b_t2_busy", {31'h0, busy}, 32'h1);
        check("b2b_t2_rdata", rdata, 32'hbeef3344);
        @(posedge clk); #1;
        check("b2b_t3_busy", {31'h0, busy}, 32'h0);
        @(posedge clk); #1;
        check("b2b_t4_ce", {31'h0, memCe}, 32'h1);
        req = 1'b0;
        @(posedge clk); #1;
        check("b2b_t5_done", {31'h0, done}, 32'h1);
        @(posedge clk); #1;
        check("b2b_t6_busy", {31'h0, busy}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
